// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the next PC, issues abortable requests to
// instruction memory, and owns the IF/ID pipeline register.
// Defining FETCH_PERF_CNT_EN adds the fetch/wait performance counters.
module fetch_unit #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] pc_value_i,
    output logic [N_BITS-1:0] new_pc_o,
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [N_BITS-1:0] jump_target_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [N_BITS-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    input  logic              imem_ready_i,
    output logic [31:0]       instr_o,
    output logic [N_BITS-1:0] pc_plus4_o,
    output logic              instr_valid_o,
    output logic              misalign_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count_o,
    output logic [31:0]       wait_count_o
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

    state_t            state, state_nxt;
    logic              active;
    logic              misaligned;
    logic              mis_cond;
    logic              mis_q;
    logic              redirect;
    logic              completion;
    logic [N_BITS-1:0] pc_inc;

    assign active     = (state == FETCH) || (state == WAIT);
    assign misaligned = (pc_value_i[1:0] != 2'b00);
    assign mis_cond   = active && misaligned;
    assign redirect   = jump_i || branch_taken_i;
    // A misaligned PC never reaches memory, so it can never complete.
    assign imem_req_o  = active && !misaligned && !reset;
    assign imem_addr_o = pc_value_i;
    assign completion  = imem_req_o && imem_ready_i && !stall_i;
    assign pc_inc      = pc_value_i + N_BITS'(4);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a redirect always restarts fetching at the target.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (imem_req_o && !imem_ready_i) state_nxt = WAIT;
            WAIT:    if (imem_ready_i) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
        if (redirect) state_nxt = FETCH;
    end

    // Next PC; the PC register has no enable, so holding means echoing pc_value_i.
    always_comb begin
        new_pc_o = pc_value_i;
        if (reset)               new_pc_o = '0;
        else if (jump_i)         new_pc_o = jump_target_i;
        else if (branch_taken_i) new_pc_o = branch_target_i;
        else if (completion)     new_pc_o = pc_inc;
    end

    // IF/ID register: invalidation beats capture, capture beats stall-hold,
    // and any other cycle leaves a bubble so nothing is issued twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_o       <= '0;
            pc_plus4_o    <= '0;
            instr_valid_o <= 1'b0;
        end else if (redirect || flush_i || mis_cond) begin
            instr_o       <= '0;
            instr_valid_o <= 1'b0;
        end else if (completion) begin
            instr_o       <= imem_rdata_i;
            pc_plus4_o    <= pc_inc;
            instr_valid_o <= 1'b1;
        end else if (!stall_i) begin
            instr_valid_o <= 1'b0;
        end
    end

    // Misalignment flag fires once on entry, not every cycle the PC sits there.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q      <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            mis_q      <= mis_cond;
            misalign_o <= mis_cond && !mis_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters, free-running and wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_o <= '0;
            wait_count_o  <= '0;
        end else begin
            if (completion)    fetch_count_o <= fetch_count_o + 32'd1;
            if (state == WAIT) wait_count_o  <= wait_count_o + 32'd1;
        end
    end
`endif

endmodule
